// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-style multi-cycle MIPS controller. Each instruction walks
//   sIF -> sID -> [sEXE -> [sMEM] -> [sWB]] -> sIF, and the datapath control
//   signals are decoded from the current state plus op/funct/zero.
//
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous active-high reset; state -> sIF, all controls 0
//   op, funct    instruction[31:26] / instruction[5:0] from the IR
//   zero         ALU zero flag, used only in sEXE of beq/bne
//   state        current state (sIF=000 sID=001 sEXE=010 sMEM=011 sWB=100 sHALT=111)
//   PCWre/PCSrc  PC load enable / next-PC select
//   IRWre        instruction register load
//   ALUSrcA/B    ALU operand selects, ALUOp ALU function
//   ExtSel       1 sign-extend, 0 zero-extend the immediate
//   RegWre/RegDst/WrRegDSrc  register-file write enable / dest select / data select
//   mRD/mWR      data-memory read / write
//   instr_count  retired-instruction count
//
// Build option
//   INSTR_COUNT_EN  when defined, instr_count counts instructions retired (edges
//                   into sIF); otherwise there is no counter and it reads 0.

module multicycle_control_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [2:0]  state,
    output logic        PCWre,
    output logic [1:0]  PCSrc,
    output logic        IRWre,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        ExtSel,
    output logic        RegWre,
    output logic [1:0]  RegDst,
    output logic        WrRegDSrc,
    output logic        mRD,
    output logic        mWR,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        SIf   = 3'b000,
        SId   = 3'b001,
        SExe  = 3'b010,
        SMem  = 3'b011,
        SWb   = 3'b100,
        SHalt = 3'b111
    } state_t;

    state_t state_q, state_d;

    // Instruction decode
    logic is_r;
    logic r_add, r_sub, r_and, r_or, r_slt, r_sll, r_jr, r_alu;
    logic op_addiu, op_andi, op_ori, op_xori, op_slti, op_imm;
    logic op_lw, op_sw, op_beq, op_bne, op_j, op_jal, op_halt;
    logic goes_exe;

    always_comb begin
        is_r     = (op == 6'b000000);
        r_add    = is_r && (funct == 6'b100000);
        r_sub    = is_r && (funct == 6'b100010);
        r_and    = is_r && (funct == 6'b100100);
        r_or     = is_r && (funct == 6'b100101);
        r_slt    = is_r && (funct == 6'b101010);
        r_sll    = is_r && (funct == 6'b000000);
        r_jr     = is_r && (funct == 6'b001000);
        r_alu    = r_add || r_sub || r_and || r_or || r_slt || r_sll;
        op_addiu = (op == 6'b001001);
        op_andi  = (op == 6'b001100);
        op_ori   = (op == 6'b001101);
        op_xori  = (op == 6'b001110);
        op_slti  = (op == 6'b001010);
        op_imm   = op_addiu || op_andi || op_ori || op_xori || op_slti;
        op_lw    = (op == 6'b100011);
        op_sw    = (op == 6'b101011);
        op_beq   = (op == 6'b000100);
        op_bne   = (op == 6'b000101);
        op_j     = (op == 6'b000010);
        op_jal   = (op == 6'b000011);
        op_halt  = (op == 6'b111111);
        // Anything not listed here (incl. unknown funct) retires from sID as a no-op
        goes_exe = r_alu || op_imm || op_lw || op_sw || op_beq || op_bne;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= SIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = SIf;
        unique case (state_q)
            SIf:   state_d = SId;
            SId: begin
                if (op_halt)       state_d = SHalt;
                else if (goes_exe) state_d = SExe;
                else               state_d = SIf;
            end
            SExe: begin
                if (op_beq || op_bne)    state_d = SIf;
                else if (op_lw || op_sw) state_d = SMem;
                else                     state_d = SWb;
            end
            SMem:  state_d = op_lw ? SWb : SIf;
            SWb:   state_d = SIf;
            SHalt: state_d = SHalt;
            default: state_d = SIf;
        endcase
    end

    // Outputs: everything is held at 0 while Reset is high so no enable
    // survives an asynchronous abort.
    always_comb begin
        state     = state_q;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 4'b0000;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (!Reset) begin
            IRWre  = (state_q == SIf);
            // PC loads on the edge that returns to sIF
            PCWre  = (state_d == SIf);
            ExtSel = !(op_andi || op_ori || op_xori);

            // PCSrc only steers the PC mux while it is being loaded
            if (PCWre) begin
                if (op_j || op_jal) begin
                    PCSrc = 2'b11;
                end else if (r_jr) begin
                    PCSrc = 2'b10;
                end else if (state_q == SExe &&
                             ((op_beq && zero) || (op_bne && !zero))) begin
                    PCSrc = 2'b01;
                end
            end

            if (state_q == SExe || state_q == SMem || state_q == SWb) begin
                ALUSrcA = r_sll;
                ALUSrcB = op_imm || op_lw || op_sw;
                if (r_sub || op_beq || op_bne)  ALUOp = 4'b0001;
                else if (r_sll)                 ALUOp = 4'b0010;
                else if (r_or || op_ori)        ALUOp = 4'b0011;
                else if (r_and || op_andi)      ALUOp = 4'b0100;
                else if (r_slt || op_slti)      ALUOp = 4'b0110;
                else if (op_xori)               ALUOp = 4'b0111;
                else                            ALUOp = 4'b0000;
            end

            // jal links PC+4 into $31 while the jump is taken
            if (state_q == SId && op_jal) begin
                RegWre = 1'b1;
                RegDst = 2'b00;
            end

            if (state_q == SMem) begin
                mRD = op_lw;
                mWR = op_sw;
            end

            if (state_q == SWb) begin
                RegWre    = 1'b1;
                RegDst    = is_r ? 2'b10 : 2'b01;
                WrRegDSrc = op_lw;
            end
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_q <= 32'd0;
        end else if (state_d == SIf) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. The stimulus process pushes one
// expected record per clock cycle of each instruction; the monitor pops one
// record at every falling edge and compares all outputs against it.
// Control record field order (20 bits):
//   state_PCWre_PCSrc_IRWre_ALUSrcA_ALUSrcB_ALUOp_ExtSel_RegWre_RegDst_WrRegDSrc_mRD_mWR

module tb_multicycle_control_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [2:0]  state;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [3:0]  ALUOp;
    logic        ExtSel;
    logic        RegWre;
    logic [1:0]  RegDst;
    logic        WrRegDSrc;
    logic        mRD;
    logic        mWR;
    logic [31:0] instr_count;

    multicycle_control_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .state       (state),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .IRWre       (IRWre),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ExtSel      (ExtSel),
        .RegWre      (RegWre),
        .RegDst      (RegDst),
        .WrRegDSrc   (WrRegDSrc),
        .mRD         (mRD),
        .mWR         (mWR),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

`ifdef INSTR_COUNT_EN
    localparam logic [31:0] CountStep = 32'd1;
`else
    localparam logic [31:0] CountStep = 32'd0;
`endif

    localparam logic [19:0] CRst = 20'b000_0_00_0_0_0_0000_0_0_00_0_0_0;
    localparam logic [19:0] CIf  = 20'b000_0_00_1_0_0_0000_1_0_00_0_0_0;
    localparam logic [19:0] CId  = 20'b001_0_00_0_0_0_0000_1_0_00_0_0_0;

    typedef struct packed {
        logic [19:0] ctl;
        logic [31:0] cnt;
    } rec_t;

    rec_t        exp_q[$];
    string       name_q[$];
    logic [31:0] exp_count;
    logic        done = 1'b0;

    int          total = 0;
    int          bad   = 0;
    rec_t        cur;
    string       nm;
    logic [19:0] got_ctl;

    task automatic push(input string n, input logic [19:0] c);
        rec_t r;
        r.ctl = c;
        r.cnt = exp_count;
        exp_q.push_back(r);
        name_q.push_back(n);
    endtask

    // Hold op/funct/zero for n cycles; inputs change just after a rising edge
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int n, input logic counts);
        op    = o;
        funct = f;
        zero  = z;
        repeat (n) @(posedge CLK);
        #1;
        if (counts) exp_count = exp_count + CountStep;
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            cur     = exp_q.pop_front();
            nm      = name_q.pop_front();
            got_ctl = {state, PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                       RegWre, RegDst, WrRegDSrc, mRD, mWR};
            total++;
            if (got_ctl !== cur.ctl || instr_count !== cur.cnt) begin
                bad++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         nm, got_ctl, instr_count, cur.ctl, cur.cnt);
            end
        end else if (done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, %0d records pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        Reset     = 1'b1;
        op        = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        exp_count = 32'd0;
        @(posedge CLK);
        #1;
        push("rst0", CRst);
        push("rst1", CRst);
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;

        // lw, zero high must not matter
        push("lw_if",  CIf);
        push("lw_id",  CId);
        push("lw_exe", 20'b010_0_00_0_0_1_0000_1_0_00_0_0_0);
        push("lw_mem", 20'b011_0_00_0_0_1_0000_1_0_00_0_1_0);
        push("lw_wb",  20'b100_1_00_0_0_1_0000_1_1_01_1_0_0);
        run(6'b100011, 6'b000000, 1'b1, 5, 1'b1);

        push("sw_if",  CIf);
        push("sw_id",  CId);
        push("sw_exe", 20'b010_0_00_0_0_1_0000_1_0_00_0_0_0);
        push("sw_mem", 20'b011_1_00_0_0_1_0000_1_0_00_0_0_1);
        run(6'b101011, 6'b000000, 1'b0, 4, 1'b1);

        push("j_if", CIf);
        push("j_id", 20'b001_1_11_0_0_0_0000_1_0_00_0_0_0);
        run(6'b000010, 6'b000000, 1'b0, 2, 1'b1);

        // sll; IF record here carries count 3 when the counter is built in
        push("sll_if",  CIf);
        push("sll_id",  CId);
        push("sll_exe", 20'b010_0_00_0_1_0_0010_1_0_00_0_0_0);
        push("sll_wb",  20'b100_1_00_0_1_0_0010_1_1_10_0_0_0);
        run(6'b000000, 6'b000000, 1'b1, 4, 1'b1);

        push("beq1_if",  CIf);
        push("beq1_id",  CId);
        push("beq1_exe", 20'b010_1_01_0_0_0_0001_1_0_00_0_0_0);
        run(6'b000100, 6'b000000, 1'b1, 3, 1'b1);

        push("beq0_if",  CIf);
        push("beq0_id",  CId);
        push("beq0_exe", 20'b010_1_00_0_0_0_0001_1_0_00_0_0_0);
        run(6'b000100, 6'b000000, 1'b0, 3, 1'b1);

        push("bne0_if",  CIf);
        push("bne0_id",  CId);
        push("bne0_exe", 20'b010_1_01_0_0_0_0001_1_0_00_0_0_0);
        run(6'b000101, 6'b000000, 1'b0, 3, 1'b1);

        push("jal_if", CIf);
        push("jal_id", 20'b001_1_11_0_0_0_0000_1_1_00_0_0_0);
        run(6'b000011, 6'b000000, 1'b1, 2, 1'b1);

        push("jr_if", CIf);
        push("jr_id", 20'b001_1_10_0_0_0_0000_1_0_00_0_0_0);
        run(6'b000000, 6'b001000, 1'b0, 2, 1'b1);

        // ori zero-extends
        push("ori_if",  20'b000_0_00_1_0_0_0000_0_0_00_0_0_0);
        push("ori_id",  20'b001_0_00_0_0_0_0000_0_0_00_0_0_0);
        push("ori_exe", 20'b010_0_00_0_0_1_0011_0_0_00_0_0_0);
        push("ori_wb",  20'b100_1_00_0_0_1_0011_0_1_01_0_0_0);
        run(6'b001101, 6'b000000, 1'b0, 4, 1'b1);

        push("unkop_if", CIf);
        push("unkop_id", 20'b001_1_00_0_0_0_0000_1_0_00_0_0_0);
        run(6'b010000, 6'b000000, 1'b0, 2, 1'b1);

        push("unkfn_if", CIf);
        push("unkfn_id", 20'b001_1_00_0_0_0_0000_1_0_00_0_0_0);
        run(6'b000000, 6'b111111, 1'b0, 2, 1'b1);

        // sw aborted by Reset right after entering sMEM: the falling-edge
        // sample in that same cycle must already show everything cleared
        push("swr_if",  CIf);
        push("swr_id",  CId);
        push("swr_exe", 20'b010_0_00_0_0_1_0000_1_0_00_0_0_0);
        run(6'b101011, 6'b000000, 1'b0, 3, 1'b0);
        Reset     = 1'b1;
        exp_count = 32'd0;
        #1;
        if (mWR !== 1'b0 || RegWre !== 1'b0 || state !== 3'b000 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL swr_abort: mWR=%b RegWre=%b state=%b cnt=%0d",
                     mWR, RegWre, state, instr_count);
        end
        push("swr_rst0", CRst);
        push("swr_rst1", CRst);
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;

        push("halt_if", CIf);
        push("halt_id", CId);
        for (int i = 0; i < 10; i++) begin
            push($sformatf("halt_%0d", i), 20'b111_0_00_0_0_0_0000_1_0_00_0_0_0);
        end
        run(6'b111111, 6'b000000, 1'b0, 12, 1'b0);
        if (state !== 3'b111 || PCWre !== 1'b0 || RegWre !== 1'b0) begin
            bad++;
            $display("FAIL halt_hold: state=%b PCWre=%b RegWre=%b", state, PCWre, RegWre);
        end

        Reset     = 1'b1;
        exp_count = 32'd0;
        #1;
        if (state !== 3'b000 || IRWre !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: state=%b IRWre=%b", state, IRWre);
        end
        push("hrst0", CRst);
        push("hrst1", CRst);
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;

        push("post_j_if", CIf);
        push("post_j_id", 20'b001_1_11_0_0_0_0000_1_0_00_0_0_0);
        run(6'b000010, 6'b000000, 1'b0, 2, 1'b1);
        if (instr_count !== exp_count) begin
            bad++;
            $display("FAIL post_j_count: got %0d want %0d", instr_count, exp_count);
        end
        push("post_if", CIf);
        run(6'b000000, 6'b100000, 1'b0, 1, 1'b0);

        done = 1'b1;
    end

endmodule
